frame_sequencer: RTL

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/frame_sequencer.sv
// ============================================================================
// frame_sequencer
// ----------------------------------------------------------------------------
// Streams one display frame of FRAME_BYTES bytes from an image controller to
// a display transmitter. For every byte the sequencer drives an address
// (byte_counter) and waits one cycle for the controller's registered read
// data. It then captures that data into tx_data and holds it with tx_valid
// until the transmitter accepts it with tx_ready.
//
// A request that arrives while a frame is in flight is remembered in a
// one-deep pending flag. The next frame starts after a single IDLE cycle.
//
// Optional feature (compile-time macro AUTO_REFRESH_EN):
//   When AUTO_REFRESH_EN is defined, a gap counter runs while the block is
//   idle. It starts a new frame on its own after REFRESH_GAP idle cycles.
//   When the macro is undefined, no gap counter is built, and frames start
//   only from frame_req or from the pending flag.
//
// Parameters:
//   FRAME_BYTES  bytes per frame, 2..1024
//   REFRESH_GAP  idle cycles between auto-refresh frames (AUTO_REFRESH_EN only)
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   rst           asynchronous active-high reset
//   frame_req     one-cycle request to stream one frame
//   byte_counter  byte address presented to the image controller
//   pixel_data    controller data for byte_counter, one edge behind it
//   tx_data       byte offered to the display transmitter
//   tx_valid      tx_data valid, held until accepted
//   tx_ready      transmitter accept strobe (ignored while tx_valid is low)
//   busy          high in every state except IDLE
//   frame_done    one-cycle pulse in the cycle after the last byte is taken
//   frame_cnt     number of completed frames, modulo 256
// ============================================================================
module frame_sequencer #(
    parameter int FRAME_BYTES = 1024,
    parameter int REFRESH_GAP = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_req,
    output logic [9:0] byte_counter,
    input  logic [7:0] pixel_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] frame_cnt
);

    // Address of the final byte in a frame. The 10-bit counter can hold the
    // largest legal frame (1024 bytes, last address 1023).
    localparam logic [9:0] LAST_BYTE = 10'(FRAME_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_CAPTURE,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [9:0] byte_counter_q, byte_counter_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       pending_q, pending_d;

    logic handshake;
    logic last_byte;
    logic auto_start;
    logic start_frame;

    // A byte counts as delivered only in SEND, and only while we are actually
    // offering it. A tx_ready seen while tx_valid is low has no effect.
    assign handshake = (state_q == ST_SEND) && tx_valid_q && tx_ready;
    assign last_byte = (byte_counter_q == LAST_BYTE);

`ifdef AUTO_REFRESH_EN
    // The gap counter only ever counts from 0 to REFRESH_GAP-1, so
    // clog2(REFRESH_GAP) bits are enough. A gap of 1 still needs one bit.
    localparam int GAP_W = (REFRESH_GAP > 1) ? $clog2(REFRESH_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(REFRESH_GAP - 1);

    logic [GAP_W-1:0] gap_q, gap_d;

    // Auto-refresh fires on the idle cycle in which the counter has reached
    // its final value. A frame_req in that same cycle merges into the same
    // start, because the two are OR-ed into a single start_frame condition.
    assign auto_start = (state_q == ST_IDLE) && (gap_q == GAP_LAST);

    // The gap counter advances on every idle cycle. It returns to zero on
    // the cycle the block leaves IDLE, and stays at zero while a frame runs,
    // so every idle stretch is timed from its first cycle.
    always_comb begin
        gap_d = gap_q;
        if (state_q == ST_IDLE) begin
            if (start_frame) begin
                gap_d = '0;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end else begin
            gap_d = '0;
        end
    end

    // Gap counter register, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end
`else
    // Without auto-refresh the gap parameter has no hardware behind it.
    // This tie-off keeps the parameter referenced.
    logic unused_refresh_gap;
    assign unused_refresh_gap = (REFRESH_GAP > 0);
    assign auto_start         = 1'b0;
`endif

    // Any of the three start sources launches a frame, but only from IDLE.
    // Requests that arrive while busy go to the pending flag instead.
    assign start_frame = (state_q == ST_IDLE) && (frame_req || pending_q || auto_start);

    // State register. Reset returns the FSM to IDLE immediately, so any
    // frame in flight is dropped without a DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Each byte takes three cycles:
    //   ADDR    - gives the controller's registered read one cycle to settle
    //   CAPTURE - loads the read data into the output register
    //   SEND    - waits for the transmitter handshake
    // After the last byte the FSM spends one cycle in DONE, then returns to
    // IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_frame) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (handshake) begin
                    state_d = last_byte ? ST_DONE : ST_ADDR;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and datapath logic, decoded from the current state.
    // - byte_counter is forced to zero in IDLE and DONE. Otherwise it only
    //   advances on the handshake edge that re-enters ADDR, so it never
    //   passes LAST_BYTE.
    // - tx_data/tx_valid load on the CAPTURE exit edge and hold through SEND
    //   until the handshake.
    // - The pending flag latches a request made in any busy state, including
    //   DONE. Further requests find it already set and are dropped. It is
    //   cleared when IDLE hands off to ADDR.
    always_comb begin
        busy           = (state_q != ST_IDLE);
        frame_done     = (state_q == ST_DONE);
        byte_counter_d = byte_counter_q;
        tx_data_d      = tx_data_q;
        tx_valid_d     = tx_valid_q;
        frame_cnt_d    = frame_cnt_q;
        pending_d      = pending_q;

        case (state_q)
            ST_IDLE: begin
                byte_counter_d = '0;
                if (start_frame) begin
                    pending_d = 1'b0;
                end
            end
            ST_CAPTURE: begin
                tx_data_d  = pixel_data;
                tx_valid_d = 1'b1;
            end
            ST_SEND: begin
                if (handshake) begin
                    tx_valid_d = 1'b0;
                    if (!last_byte) begin
                        byte_counter_d = byte_counter_q + 10'd1;
                    end
                end
            end
            ST_DONE: begin
                frame_cnt_d    = frame_cnt_q + 8'd1;
                byte_counter_d = '0;
            end
            default: begin
                byte_counter_d = byte_counter_q;
            end
        endcase

        if (busy && frame_req) begin
            pending_d = 1'b1;
        end
    end

    // Datapath registers. Reset clears them all immediately, so outputs
    // fall to zero without a clock and the frame count is unaffected by an
    // abandoned frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_counter_q <= '0;
            tx_data_q      <= '0;
            tx_valid_q     <= 1'b0;
            frame_cnt_q    <= '0;
            pending_q      <= 1'b0;
        end else begin
            byte_counter_q <= byte_counter_d;
            tx_data_q      <= tx_data_d;
            tx_valid_q     <= tx_valid_d;
            frame_cnt_q    <= frame_cnt_d;
            pending_q      <= pending_d;
        end
    end

    assign byte_counter = byte_counter_q;
    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign frame_cnt    = frame_cnt_q;

endmodule
